vram_arb: RTL
=============

Name: vram_arb

Overview:
- Arbitrates a single VRAM bank (one `dpram` port, 8-bit x 4K) between two requesters:
  - the VDC render fetcher (high priority);
  - the CPU bus path (low priority, stalled via WAITB).
- New arbitration slots start only on VDC clock-enable cycles.
- Includes anti-starvation aging so the CPU cannot be locked out by back-to-back render fetches.
- Instantiated once per VRAM bank, between `epochtv1` and `vrama`/`vramb`.

Parameters:
- AWIDTH, 12, VRAM address width.
- STARVE_LIMIT, 4, number of consecutive CE slots the CPU may lose before it is forced to win. Range 0..15; 0 means strict render priority.

Ports:
- CLK  in  1  system clock (2x video XTAL).
- RES  in  1  synchronous active-high reset.
- CE  in  1  VDC clock enable; arbitration decisions only on CLK edges with CE=1.
- REN_REQ  in  1  render read request (level).
- REN_A  in  AWIDTH  render address.
- REN_D  out  8  render read data, valid while REN_ACK=1.
- REN_ACK  out  1  one-CLK completion pulse.
- CPU_REQ  in  1  CPU access request (level).
- CPU_WE  in  1  1=write, 0=read.
- CPU_A  in  AWIDTH  CPU address.
- CPU_DI  in  8  CPU write data.
- CPU_DO  out  8  CPU read data, valid while CPU_ACK=1.
- CPU_ACK  out  1  one-CLK completion pulse.
- WAITB  out  1  CPU wait, active low.
- MA  out  AWIDTH  RAM address.
- MDO  out  8  RAM write data.
- MDI  in  8  RAM read data; valid the CLK edge after the read strobe edge.
- nMRD  out  1  RAM read strobe, active low.
- nMWR  out  1  RAM write strobe, active low.

Behaviour:
- Reset: RES=1 at any edge forces the following, overriding everything else:
  - state IDLE;
  - nMRD=nMWR=1;
  - REN_ACK=CPU_ACK=0;
  - REN_D=CPU_DO=MA=MDO=0;
  - starvation counter=0.
  - An in-flight access is dropped with no ACK.
- States: IDLE, STROBE, DATA. All outputs are registered except WAITB.
- Grant (state IDLE, CE=1, any REQ=1):
  - Winner is CPU if CPU_REQ & (~REN_REQ | (STARVE_LIMIT!=0 & cnt==STARVE_LIMIT)); otherwise render.
  - Latch winner ID; MA<=winner address; go to STROBE.
  - Read: nMRD<=0. CPU write: nMWR<=0 and MDO<=CPU_DI.
- STROBE (next edge):
  - nMRD<=1, nMWR<=1.
  - Write: CPU_ACK<=1; go to IDLE.
  - Read: go to DATA.
- DATA (next edge): winner's D<=MDI and winner's ACK<=1; go to IDLE.
- Latency, counted from the grant edge E0:
  - read ACK high in the cycle after E2;
  - write ACK high in the cycle after E1;
  - strobes are low for exactly one CLK.
- ACK pulses are exactly one CLK. D outputs hold their value until the next ACK for the same port.
- Requester rule: hold REQ, A, WE and DI stable until ACK. Drop REQ during the ACK cycle, or a still-high REQ is taken as a new request at the next CE edge.
- No grant occurs in STROBE or DATA even if CE=1; CE edges falling in those states are skipped.
- Starvation counter (4-bit):
  - +1 at each grant edge where CPU_REQ=1 and render wins, saturating at STARVE_LIMIT;
  - cleared on any CPU grant;
  - unchanged when CPU_REQ=0.
- WAITB = ~CPU_REQ | CPU_ACK (combinational), so it goes low the same cycle the request is raised.
- No request pending at a CE edge: stay IDLE, strobes high, MA holds its last value.
- AWIDTH addresses wrap naturally; there is no range checking.

Test Plan:
- Reset then single render read: preload RAM[0x123]=0x5A, REN_REQ at CE edge E0 with REN_A=0x123 → nMRD low only in cycle E0..E1 with MA=0x123; REN_ACK=1 and REN_D=0x5A in cycle E2..E3; CPU_ACK=0.
- CPU write then read with CE every 7 CLK: write 0xC3 to 0x0FF → nMWR one-CLK pulse with MDO=0xC3 and CPU_ACK after E1; WAITB low from REQ until the ACK cycle. Read back 0x0FF → CPU_DO=0xC3.
- Simultaneous requests, STARVE_LIMIT=4, REN_REQ held high continuously, CPU_REQ held high → render wins grant slots 1–4, CPU wins slot 5 (cnt reaches 4), counter returns to 0, render resumes at slot 6.
- STARVE_LIMIT=0 with the same stimulus → CPU is never granted while REN_REQ=1; CPU is granted at the first slot after REN_REQ drops.
- CE held high every CLK, back-to-back render reads → grants at E0, E3, E6; no strobe overlap; each REN_ACK is one CLK wide.
- RES asserted in STROBE of a read → next edge nMRD=1, state IDLE, no REN_ACK. After release, a REN_REQ still high is re-granted at the next CE edge with correct data.

Source files
------------

// File: rtl/vram_arb_if.sv
// vram_arb_if: requester and VRAM-port signals of one arbitrated bank
interface vram_arb_if #(parameter int AWIDTH = 12);
  logic CE;
  logic REN_REQ;
  logic [AWIDTH-1:0] REN_A;
  logic [7:0] REN_D;
  logic REN_ACK;
  logic CPU_REQ;
  logic CPU_WE;
  logic [AWIDTH-1:0] CPU_A;
  logic [7:0] CPU_DI;
  logic [7:0] CPU_DO;
  logic CPU_ACK;
  logic WAITB;
  logic [AWIDTH-1:0] MA;
  logic [7:0] MDO;
  logic [7:0] MDI;
  logic nMRD;
  logic nMWR;
  modport slave (
    input CE, REN_REQ, REN_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, MDI,
    output REN_D, REN_ACK, CPU_DO, CPU_ACK, WAITB, MA, MDO, nMRD, nMWR
  );
  modport master (
    output CE, REN_REQ, REN_A, CPU_REQ, CPU_WE, CPU_A, CPU_DI, MDI,
    input REN_D, REN_ACK, CPU_DO, CPU_ACK, WAITB, MA, MDO, nMRD, nMWR
  );
endinterface

// File: rtl/vram_arb.sv
// vram_arb: render/CPU arbiter for one VRAM bank with CPU anti-starvation aging
module vram_arb #(
  parameter int AWIDTH = 12,
  parameter int STARVE_LIMIT = 4
) (
  input logic CLK,
  input logic RES,
  vram_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STROBE, DATA} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state, state_nxt;
  logic sel_cpu, wr, grant, cpu_win, cpu_wr;
  logic [3:0] cnt;
  assign grant = state == IDLE && bus.CE && (bus.REN_REQ || bus.CPU_REQ);
  assign cpu_win = bus.CPU_REQ && (!bus.REN_REQ || (LIM != 4'd0 && cnt == LIM));
  assign cpu_wr = cpu_win && bus.CPU_WE;
  assign bus.WAITB = ~bus.CPU_REQ | bus.CPU_ACK;
  always_comb begin
    state_nxt = state == IDLE ? (grant ? STROBE : IDLE) :
                state == STROBE ? (wr ? IDLE : DATA) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RES) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      bus.nMRD <= 1'b1;
      bus.nMWR <= 1'b1;
      bus.REN_ACK <= 1'b0;
      bus.CPU_ACK <= 1'b0;
      bus.REN_D <= '0;
      bus.CPU_DO <= '0;
      bus.MA <= '0;
      bus.MDO <= '0;
      cnt <= '0;
      sel_cpu <= 1'b0;
      wr <= 1'b0;
    end else begin
      bus.REN_ACK <= 1'b0;
      bus.CPU_ACK <= 1'b0;
      if (grant) begin
        sel_cpu <= cpu_win;
        wr <= cpu_wr;
        bus.MA <= cpu_win ? bus.CPU_A : bus.REN_A;
        bus.nMRD <= cpu_wr;
        bus.nMWR <= ~cpu_wr;
        if (cpu_wr) bus.MDO <= bus.CPU_DI;
        // aging only advances while the CPU is actually waiting
        cnt <= cpu_win ? 4'd0 : (bus.CPU_REQ && cnt != LIM) ? cnt + 4'd1 : cnt;
      end
      if (state == STROBE) begin
        bus.nMRD <= 1'b1;
        bus.nMWR <= 1'b1;
        if (wr) bus.CPU_ACK <= 1'b1;
      end
      if (state == DATA) begin
        if (sel_cpu) begin
          bus.CPU_DO <= bus.MDI;
          bus.CPU_ACK <= 1'b1;
        end else begin
          bus.REN_D <= bus.MDI;
          bus.REN_ACK <= 1'b1;
        end
      end
    end
  end
endmodule
